// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive/transmit family.
//               Receiver FSM state encoding, parity-sense constants and the
//               bit-timer width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Width of a down-counter that must hold clocks_per_bit-1.
  function automatic int uart_timer_bits(input int clocks_per_bit);
    return $clog2(clocks_per_bit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for an asynchronous single-bit input.
//               The reset value is a parameter so idle-high serial lines and
//               idle-low flow-control inputs can share this block.
// Ports       : clk  - sampling clock
//               rst  - asynchronous active-high reset
//               d_i  - asynchronous input
//               q_o  - synchronized output (2 clk latency)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  import uart_pkg::*;

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_framed
// Description : Parametrised UART receiver with mid-bit sampling, start-bit
//               glitch rejection, stop-bit framing check and optional parity.
//               Optional feature macro: UART_RX_PARITY_EN (adds a parity bit
//               after the payload and makes out_parity_err live).
// Ports       : clk            - sole clock
//               rst            - asynchronous active-high reset
//               ser_rx         - asynchronous serial line, idles high
//               out_data       - last received payload (LSB first on wire)
//               out_valid      - 1-cycle pulse, good frame
//               out_frame_err  - 1-cycle pulse, stop bit sampled low
//               out_parity_err - 1-cycle pulse, parity mismatch
//               busy           - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4,
  parameter int data_bits      = 8,
  parameter bit parity_odd     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_rx,
  output logic [data_bits-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_frame_err,
  output logic                 out_parity_err,
  output logic                 busy
);

  localparam int            TW          = uart_timer_bits(clocks_per_bit);
  localparam int            IW          = $clog2(data_bits);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(clocks_per_bit / 2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(clocks_per_bit - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(data_bits - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic [data_bits-1:0] data_q, data_d;
  logic                 wait_high_q, wait_high_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic par_fail;
  assign par_fail = (((^shift_q) ^ par_q) != parity_odd);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ser_rx),
    .q_o (rx_s)
  );

  assign tick = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    wait_high_d = wait_high_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    perr_d      = 1'b0;
`endif

    if ((state_q != IDLE) && !tick) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        // After a framing error the line must be seen high again before a
        // new start bit is accepted; a held break yields only one error.
        if (wait_high_q) begin
          if (rx_s) begin
            wait_high_d = 1'b0;
          end
        end else if (!rx_s) begin
          state_d = START;
          timer_d = HALF_RELOAD;
        end
      end

      START: begin
        if (tick) begin
          timer_d = FULL_RELOAD;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end

      DATA: begin
        if (tick) begin
          timer_d = FULL_RELOAD;
          shift_d = {rx_s, shift_q[data_bits-1:1]};
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick) begin
          timer_d = FULL_RELOAD;
          par_d   = rx_s;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end

      STOP: begin
        // Act at mid stop bit; the second half is ignored so a back-to-back
        // start edge can be caught from IDLE on the very next cycle.
        if (tick) begin
          state_d = IDLE;
          data_d  = shift_q;
          if (!rx_s) begin
            ferr_d      = 1'b1;
            wait_high_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_fail) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      wait_high_q <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      wait_high_q <= wait_high_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_frame_err = ferr_q;
  assign busy          = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign out_parity_err = perr_q;
`else
  assign out_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_framed
// Description : Self-checking bench for uart_rx_framed. Instance A uses the
//               defaults (4 clk/bit, 8 bits); instance B uses 16 clk/bit and
//               9 bits. A cycle-indexed expectation table is filled from the
//               frame-level timing rules and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_framed;

`ifdef UART_RX_PARITY_EN
  localparam int P_EN = 1;
`else
  localparam int P_EN = 0;
`endif
  localparam int MAXC  = 4000;
  localparam int CPB_A = 4;
  localparam int NB_A  = 8;
  localparam int CPB_B = 16;
  localparam int NB_B  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rx_a, rx_b;
  logic [7:0] data_a;
  logic [8:0] data_b;
  logic       valid_a, ferr_a, perr_a, busy_a;
  logic       valid_b, ferr_b, perr_b, busy_b;

  uart_rx_framed #(.clocks_per_bit(CPB_A), .data_bits(NB_A), .parity_odd(1'b0)) u_dut_a (
    .clk(clk), .rst(rst_a), .ser_rx(rx_a), .out_data(data_a), .out_valid(valid_a),
    .out_frame_err(ferr_a), .out_parity_err(perr_a), .busy(busy_a));

  uart_rx_framed #(.clocks_per_bit(CPB_B), .data_bits(NB_B), .parity_odd(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .ser_rx(rx_b), .out_data(data_b), .out_valid(valid_b),
    .out_frame_err(ferr_b), .out_parity_err(perr_b), .busy(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle behaviour, [instance][cycle].
  bit         m_valid [2][MAXC];
  bit         m_ferr  [2][MAXC];
  bit         m_perr  [2][MAXC];
  bit         m_busy  [2][MAXC];
  bit         m_dset  [2][MAXC];
  logic [8:0] m_dval  [2][MAXC];
  logic [8:0] md [2];

  bit cmp_en = 1'b0;
  int last_valid_a = -1;
  int busy_cnt_a = 0;
  int perr_cnt_a = 0;
  int valid_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: strobe lands a fixed latency after the start edge;
  // busy covers start-detect+1 up to the cycle before the strobe.
  task automatic model_frame(input int inst, input int e, input logic [8:0] payload,
                             input bit par_bit, input bit stop_bit);
    int cpb, nb, strobe;
    logic [8:0] pm;
    cpb    = (inst == 0) ? CPB_A : CPB_B;
    nb     = (inst == 0) ? NB_A : NB_B;
    pm     = (nb == 9) ? payload : (payload & 9'h0FF);
    strobe = e + 3 + cpb / 2 + (nb + P_EN + 1) * cpb;
    if (strobe < MAXC) begin
      for (int c = e + 3; c < strobe; c++) m_busy[inst][c] = 1'b1;
      m_dset[inst][strobe] = 1'b1;
      m_dval[inst][strobe] = pm;
      if (!stop_bit)                             m_ferr[inst][strobe]  = 1'b1;
      else if (P_EN == 1 && ((^pm) ^ par_bit))   m_perr[inst][strobe]  = 1'b1;
      else                                       m_valid[inst][strobe] = 1'b1;
    end
  endtask

  task automatic model_glitch(input int inst, input int e);
    int cpb;
    cpb = (inst == 0) ? CPB_A : CPB_B;
    for (int c = e + 3; c < e + 3 + cpb / 2; c++) m_busy[inst][c] = 1'b1;
  endtask

  task automatic model_reset(input int inst, input int from_c);
    for (int c = from_c; c < MAXC; c++) begin
      m_valid[inst][c] = 1'b0; m_ferr[inst][c] = 1'b0; m_perr[inst][c] = 1'b0;
      m_busy[inst][c]  = 1'b0; m_dset[inst][c] = 1'b0;
    end
    m_dset[inst][from_c] = 1'b1;
    m_dval[inst][from_c] = 9'h000;
  endtask

  always @(negedge clk) begin
    if (cmp_en && cyc < MAXC) begin
      for (int i = 0; i < 2; i++) if (m_dset[i][cyc]) md[i] = m_dval[i][cyc];
      check("valid_a", valid_a, m_valid[0][cyc]);
      check("ferr_a",  ferr_a,  m_ferr[0][cyc]);
      check("perr_a",  perr_a,  m_perr[0][cyc]);
      check("busy_a",  busy_a,  m_busy[0][cyc]);
      check("data_a",  data_a,  md[0]);
      check("valid_b", valid_b, m_valid[1][cyc]);
      check("ferr_b",  ferr_b,  m_ferr[1][cyc]);
      check("perr_b",  perr_b,  m_perr[1][cyc]);
      check("busy_b",  busy_b,  m_busy[1][cyc]);
      check("data_b",  data_b,  md[1]);
      if (valid_a) last_valid_a = cyc;
      if (busy_a)  busy_cnt_a++;
      if (perr_a)  perr_cnt_a++;
      if (valid_b) valid_cnt_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_line(input int inst, input bit v);
    if (inst == 0) rx_a = v;
    else           rx_b = v;
  endtask

  // Drives one whole frame; flip_par inverts the correct (even) parity bit.
  task automatic send(input int inst, input logic [8:0] payload, input bit stop_bit,
                      input bit flip_par);
    int cpb, nb;
    bit pb;
    logic [8:0] pm;
    cpb = (inst == 0) ? CPB_A : CPB_B;
    nb  = (inst == 0) ? NB_A : NB_B;
    pm  = (nb == 9) ? payload : (payload & 9'h0FF);
    pb  = (^pm) ^ flip_par;
    model_frame(inst, cyc, payload, pb, stop_bit);
    set_line(inst, 1'b0);
    repeat (cpb) tick();
    for (int k = 0; k < nb; k++) begin
      set_line(inst, pm[k]);
      repeat (cpb) tick();
    end
    if (P_EN == 1) begin
      set_line(inst, pb);
      repeat (cpb) tick();
    end
    set_line(inst, stop_bit);
    repeat (cpb) tick();
    set_line(inst, 1'b1);
  endtask

  initial begin : main
    int e, b0, p0;
    md[0] = '0;
    md[1] = '0;
    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    cmp_en = 1'b1;
    repeat (100) tick();

    check("rst_data_a",  data_a,  8'h00);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_busy_a",  busy_a,  1'b0);
    check("rst_busy_b",  busy_b,  1'b0);

    // Default frame and its latency from the pin edge.
    e = cyc;
    send(0, 9'h0A5, 1'b1, 1'b0);
    repeat (10) tick();
    check("a5_latency", last_valid_a - e, (P_EN == 1) ? 45 : 41);
    check("a5_data", data_a, 8'hA5);

    // One-cycle low glitch: rejected, busy for clocks_per_bit/2 = 2 cycles.
    b0 = busy_cnt_a;
    e  = cyc;
    model_glitch(0, e);
    rx_a = 1'b0;
    tick();
    rx_a = 1'b1;
    repeat (10) tick();
    check("glitch_busy_cycles", busy_cnt_a - b0, 2);

    // Bad stop bit, then a good frame.
    send(0, 9'h03C, 1'b0, 1'b0);
    repeat (4) tick();
    check("ferr_data", data_a, 8'h3C);
    send(0, 9'h081, 1'b1, 1'b0);
    repeat (10) tick();
    check("after_ferr_data", data_a, 8'h81);

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt_a;
    send(0, 9'h007, 1'b1, 1'b1);
    repeat (4) tick();
    send(0, 9'h007, 1'b1, 1'b0);
    repeat (10) tick();
    check("parity_err_count", perr_cnt_a - p0, 1);
`else
    p0 = 0;
`endif

    // Break: line held low well past a frame gives a single frame error.
    model_frame(0, cyc, 9'h000, 1'b0, 1'b0);
    rx_a = 1'b0;
    repeat ((NB_A + P_EN + 2) * CPB_A + 60) tick();
    rx_a = 1'b1;
    repeat (5) tick();
    check("break_busy", busy_a, 1'b0);
    send(0, 9'h05A, 1'b1, 1'b0);
    repeat (10) tick();
    check("after_break_data", data_a, 8'h5A);

    // Instance B: three back-to-back 9-bit frames, then reset mid-frame.
    send(1, 9'h1FF, 1'b1, 1'b0);
    send(1, 9'h000, 1'b1, 1'b0);
    send(1, 9'h155, 1'b1, 1'b0);
    model_frame(1, cyc, 9'h000, 1'b0, 1'b0);
    rx_b = 1'b0;
    repeat (60) tick();
    check("b_data_before_rst", data_b, 9'h155);
    check("b_busy_before_rst", busy_b, 1'b1);
    model_reset(1, cyc);
    rst_b = 1'b1;
    #1;
    check("b_busy_in_rst", busy_b, 1'b0);
    check("b_data_in_rst", data_b, 9'h000);
    rx_b = 1'b1;
    repeat (2) tick();
    rst_b = 1'b0;
    repeat (250) tick();
    check("b_valid_count", valid_cnt_b, 3);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver, the next generation of the serial-input block. It adds configurable data width, mid-bit sampling, start-bit glitch rejection, stop-bit framing checks and optional parity checking. It sits between the board serial pin and any byte/word consumer, for example a command decoder or a FIFO. Received words are presented with a single-cycle valid strobe and error flags.

## Interface
- `clocks_per_bit`, default 4: clk cycles per serial bit; must be ≥ 4 and even.
- `data_bits`, default 8: payload bits per frame; legal range 5..9.
- `parity_odd`, default 0: 0 selects even parity, 1 selects odd. Only meaningful when parity is compiled in.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `ser_rx`  in  1  asynchronous serial line; idles high.
- `out_data`  out  data_bits  last received payload, LSB first on the wire.
- `out_valid`  out  1  one-cycle pulse; frame good.
- `out_frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `out_parity_err`  out  1  one-cycle pulse; parity mismatch (stop bit good).
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- `ser_rx` passes through a 2-FF synchronizer, producing `rx_s`. The synchronizer resets to 1.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when `rx_s`==0, go to START and load the timer with `clocks_per_bit/2 - 1`.
- Timer rule: the timer decrements each cycle. A state acts only when the timer is 0, and then reloads it with `clocks_per_bit - 1`.
- START (timer 0): if `rx_s`==1, treat as a glitch and return to IDLE with no flags. Otherwise go to DATA with bit index 0.
- DATA (timer 0): shift `rx_s` into the MSB of the shift register (right shift). After `data_bits` samples, go to PARITY if parity is compiled in, else to STOP.
- PARITY (timer 0): capture the parity bit, then go to STOP.
- STOP (timer 0): go to IDLE. Then:
  - `out_data` ← shift register on every completed frame, good or bad.
  - If `rx_s`==0, pulse `out_frame_err`.
  - Else if the parity check fails, pulse `out_parity_err`.
  - Else pulse `out_valid`.
  - At most one of the three strobes is high in any cycle.
- Parity check: with `parity_odd`=0, the XOR of payload and parity bit must be 0; with `parity_odd`=1, it must be 1.
- Back-to-back frames: from IDLE, a start edge is accepted in the cycle right after STOP completes, because the second half of the stop bit is ignored.
- A line held low (break) produces one frame error. The FSM then re-enters START only after `rx_s` has been seen high in IDLE.

## Timing
- Reset values:
  - `out_data` = 0; `out_valid`, `out_frame_err`, `out_parity_err`, `busy` = 0.
  - FSM = IDLE; synchronizer = 1.
- Reset mid-frame aborts immediately: no strobe, and the partial word is discarded.
- Let t0 be the first cycle in which IDLE sees `rx_s`==0 (2 cycles after the pin edge).
  - Start-bit sample at t0 + `clocks_per_bit/2`.
  - Sample k, counting data, parity and stop bits from 1, at t0 + `clocks_per_bit/2` + k·`clocks_per_bit`.
- Strobes and `out_data` are registered: they are valid in the cycle after the stop sample, and the strobe is high for exactly 1 cycle.
- Latency, pin edge to `out_valid`: 3 + `clocks_per_bit/2` + (`data_bits` + P + 1)·`clocks_per_bit`, where P = 1 with parity, else 0.
- `busy` rises at t0+1 and falls in the same cycle the strobe rises.
- There is no backpressure: the consumer must take `out_data` before the next strobe. `out_data` is stable for at least one full frame.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - The PARITY state exists and one parity bit follows the payload.
  - `parity_odd` selects the sense of the check.
  - `out_parity_err` is live.
- Undefined:
  - The PARITY state and parity logic are removed; the frame is start + payload + stop.
  - `out_parity_err` is tied to 0 and `parity_odd` is ignored.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `PARITY_EVEN`/`PARITY_ODD` constants.
  - `uart_timer_bits(clocks_per_bit)` helper = $clog2(clocks_per_bit).
- Sub-module `uart_sync2`: 2-FF synchronizer with parametrised reset value. It is reused by the planned transmitter and flow-control inputs.

## Test plan
- Reset release, line idle high for 100 cycles → all outputs 0, `busy`=0.
- Defaults (`clocks_per_bit`=4, 8 bits, no parity), send 0xA5 → `out_data`=0xA5; `out_valid` high for 1 cycle, 41 cycles after the pin start edge; no error strobes.
- Drive `ser_rx` low for 1 cycle only → no strobe; `busy` high for exactly 2 cycles.
- Send 0x3C with the stop bit low → `out_frame_err` pulse, `out_data`=0x3C, `out_valid` stays 0. A following good frame 0x81 → `out_valid`, `out_data`=0x81.
- With `UART_RX_PARITY_EN`, `parity_odd`=0:
  - Send 0x07 with parity bit 0 → `out_parity_err`.
  - Send 0x07 with parity bit 1 → `out_valid`.
- `data_bits`=9, `clocks_per_bit`=16: frames 0x1FF, 0x000, 0x155 back-to-back (no idle gap) → three `out_valid` strobes with matching data. Assert `rst` mid-way through the fourth frame → no strobe; `busy`=0 immediately.
